logic_unit: RTL

- Parametrised, registered bitwise logic unit for the CPU datapath ALU slice.
- Supersedes the single-bit gate primitives with one WIDTH-wide block that selects among eight bitwise operations and produces status flags.
- Sits between the operand-read stage and the writeback mux.
- Has valid/ready handshakes on both sides, with a one-entry skid buffer so full throughput is kept under backpressure.

---
 rtl/logic_pkg.sv | 19 +
 rtl/lu_core.sv | 42 ++++
 rtl/logic_unit.sv | 106 ++++++++++
 3 files changed

// File: rtl/logic_pkg.sv
// logic_pkg: shared definitions for the bitwise logic unit.
//   LU_OP_W  - width of the operation select field
//   lu_op_e  - operation codes, shared by the decoder and the bench
package logic_pkg;

  localparam int unsigned LU_OP_W = 3;

  typedef enum logic [LU_OP_W-1:0] {
    LU_AND   = 3'd0,  // a & b
    LU_OR    = 3'd1,  // a | b
    LU_XOR   = 3'd2,  // a ^ b
    LU_NAND  = 3'd3,  // ~(a & b)
    LU_NOR   = 3'd4,  // ~(a | b)
    LU_XNOR  = 3'd5,  // ~(a ^ b)
    LU_ANDN  = 3'd6,  // a & ~b
    LU_PASSA = 3'd7   // a
  } lu_op_e;

endpackage

// File: rtl/lu_core.sv
// lu_core: purely combinational WIDTH-wide bitwise operation plus status flags.
// Ports:
//   op   - operation select (lu_op_e encoding)
//   a, b - operands
//   y    - result
//   zero - result is all zeros
//   neg  - result MSB
//   par  - XOR-reduction of the result (1 = odd number of ones)
module lu_core
  import logic_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [LU_OP_W-1:0] op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [WIDTH-1:0]   y,
  output logic               zero,
  output logic               neg,
  output logic               par
);

  always_comb begin
    y = '0;
    case (lu_op_e'(op))
      LU_AND:   y = a & b;
      LU_OR:    y = a | b;
      LU_XOR:   y = a ^ b;
      LU_NAND:  y = ~(a & b);
      LU_NOR:   y = ~(a | b);
      LU_XNOR:  y = ~(a ^ b);
      LU_ANDN:  y = a & ~b;
      LU_PASSA: y = a;
      default:  y = '0;
    endcase
  end

  assign zero = ~|y;
  assign neg  = y[WIDTH-1];
  assign par  = ^y;

endmodule

// File: rtl/logic_unit.sv
// logic_unit: registered bitwise logic unit with valid/ready on both sides
// and a one-entry skid buffer so full throughput survives backpressure.
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   in_valid / in_ready  - operand beat handshake
//   in_op, in_a, in_b    - operation select and operands
//   out_valid / out_ready- result beat handshake
//   out_y                - result
//   out_zero/neg/par     - result flags (all zeros / MSB / odd parity)
module logic_unit
  import logic_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LU_OP_W-1:0] in_op,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_y,
  output logic               out_zero,
  output logic               out_neg,
  output logic               out_par
);

  logic [WIDTH-1:0] core_y;
  logic             core_zero;
  logic             core_neg;
  logic             core_par;

  lu_core #(.WIDTH(WIDTH)) u_core (
    .op   (in_op),
    .a    (in_a),
    .b    (in_b),
    .y    (core_y),
    .zero (core_zero),
    .neg  (core_neg),
    .par  (core_par)
  );

  // Output register (OR) and skid register (SK)
  logic [WIDTH-1:0] or_y,   sk_y;
  logic             or_zero, sk_zero;
  logic             or_neg,  sk_neg;
  logic             or_par,  sk_par;
  logic             or_valid, sk_valid;

  logic acc;
  logic or_free;

  // in_ready comes only from the SK valid flop, never from out_ready
  assign in_ready = ~sk_valid;
  assign acc      = in_valid & in_ready;
  assign or_free  = ~or_valid | out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      or_y     <= '0;
      or_zero  <= 1'b0;
      or_neg   <= 1'b0;
      or_par   <= 1'b0;
      or_valid <= 1'b0;
      sk_y     <= '0;
      sk_zero  <= 1'b0;
      sk_neg   <= 1'b0;
      sk_par   <= 1'b0;
      sk_valid <= 1'b0;
    end else if (sk_valid) begin
      // SK is only ever full behind a full OR; refill OR from SK on drain
      if (out_ready) begin
        or_y     <= sk_y;
        or_zero  <= sk_zero;
        or_neg   <= sk_neg;
        or_par   <= sk_par;
        sk_valid <= 1'b0;
      end
    end else if (or_free) begin
      if (acc) begin
        or_y     <= core_y;
        or_zero  <= core_zero;
        or_neg   <= core_neg;
        or_par   <= core_par;
        or_valid <= 1'b1;
      end else begin
        or_valid <= 1'b0;
      end
    end else if (acc) begin
      sk_y     <= core_y;
      sk_zero  <= core_zero;
      sk_neg   <= core_neg;
      sk_par   <= core_par;
      sk_valid <= 1'b1;
    end
  end

  assign out_valid = or_valid;
  assign out_y     = or_y;
  assign out_zero  = or_zero;
  assign out_neg   = or_neg;
  assign out_par   = or_par;

endmodule
